// File: rtl/adc_trig_mc.sv
// rtl/adc_trig_mc.sv - multi-channel ADC event trigger with deglitch, arm holdoff and post-trigger count
module adc_trig_mc #(
  parameter int DW    = 8,
  parameter int NCH   = 2,
  parameter int DLY_W = 4,
  parameter int HO_W  = 16,
  localparam int CSW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLK_EN,
  input  logic [NCH*DW-1:0] DATA_IN,
  input  logic [CSW-1:0]    CH_SEL,
  input  logic [DW-1:0]     TRG_LV_UP,
  input  logic [DW-1:0]     TRG_LV_DOWN,
  input  logic [1:0]        MODE,
  input  logic [DLY_W-1:0]  DELAY,
  input  logic [HO_W-1:0]   HOLDOFF,
  input  logic [HO_W-1:0]   POST_CNT,
  input  logic              TRG_EV_EN,
  input  logic              TRG_BYPASS,
  output logic              trig_out,
  output logic              capture_done,
  output logic              armed,
  output logic [CSW-1:0]    trig_ch
);

  typedef enum logic [2:0] {
    S_DISARMED, S_HOLDOFF, S_FIRST, S_LAST, S_POST, S_DONE
  } state_t;

  state_t            state_q;
  logic [NCH*DW-1:0] s1_q;
  logic              first_q, last_q;
  logic [CSW-1:0]    ch_q;
  logic [1:0]        mode_q;
  logic [DLY_W-1:0]  dly_q, dly_cnt_q;
  logic [HO_W-1:0]   post_lat_q, ho_cnt_q, post_cnt_q;
  logic              trig_q, done_q, armed_q;

  logic [DW-1:0]     sample;
  logic              hi, lo, inwin;
  logic              first_d, last_d;

  // Out-of-range channel selects read as zero rather than wrapping.
  always_comb begin
    sample = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == CSW'(c)) sample = s1_q[c*DW +: DW];
    end
    hi    = sample > TRG_LV_UP;
    lo    = sample < TRG_LV_DOWN;
    inwin = (TRG_LV_DOWN < sample) && (sample < TRG_LV_UP);
    first_d = 1'b0;
    last_d  = 1'b0;
    case (mode_q)
      2'd0: begin first_d = lo;     last_d = hi;     end
      2'd1: begin first_d = hi;     last_d = lo;     end
      2'd2: begin first_d = !inwin; last_d = inwin;  end
      default: begin first_d = inwin; last_d = !inwin; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      s1_q    <= DATA_IN;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_DISARMED;
      ch_q       <= '0;
      mode_q     <= '0;
      dly_q      <= '0;
      post_lat_q <= '0;
      ho_cnt_q   <= '0;
      dly_cnt_q  <= '0;
      post_cnt_q <= '0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      armed_q <= (state_q == S_FIRST) || (state_q == S_LAST);
      trig_q  <= TRG_BYPASS;
      // Disarm wins over every other transition, including a same-edge trigger.
      if (!TRG_EV_EN) begin
        state_q    <= S_DISARMED;
        ho_cnt_q   <= '0;
        dly_cnt_q  <= '0;
        post_cnt_q <= '0;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          S_DISARMED: begin
            ch_q       <= CH_SEL;
            mode_q     <= MODE;
            dly_q      <= DELAY;
            post_lat_q <= POST_CNT;
            ho_cnt_q   <= HOLDOFF;
            dly_cnt_q  <= DELAY;
            state_q    <= (HOLDOFF != '0) ? S_HOLDOFF : S_FIRST;
          end
          S_HOLDOFF: if (CLK_EN) begin
            ho_cnt_q <= ho_cnt_q - 1'b1;
            if (ho_cnt_q == HO_W'(1)) begin
              dly_cnt_q <= dly_q;
              state_q   <= S_FIRST;
            end
          end
          S_FIRST: if (CLK_EN) begin
            if (!first_q)              dly_cnt_q <= dly_q;
            else if (dly_cnt_q == '0)  state_q   <= S_LAST;
            else                       dly_cnt_q <= dly_cnt_q - 1'b1;
          end
          S_LAST: if (CLK_EN && last_q) begin
            trig_q <= 1'b1;
            if (post_lat_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              post_cnt_q <= post_lat_q;
              state_q    <= S_POST;
            end
          end
          S_POST: begin
            trig_q <= 1'b1;
            if (CLK_EN) begin
              post_cnt_q <= post_cnt_q - 1'b1;
              if (post_cnt_q == HO_W'(1)) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
          S_DONE:  trig_q  <= 1'b1;
          default: state_q <= S_DISARMED;
        endcase
      end
    end
  end

  assign trig_out     = trig_q;
  assign capture_done = done_q;
  assign armed        = armed_q;
  assign trig_ch      = ch_q;

endmodule

// File: tb/tb_adc_trig_mc.sv
// tb/tb_adc_trig_mc.sv - scoreboard bench for adc_trig_mc with an event-level reference model
module tb_adc_trig_mc;
  localparam int DW = 8, NCH = 2, DLY_W = 4, HO_W = 16, CSW = 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              CLK_EN = 1'b0;
  logic [NCH*DW-1:0] DATA_IN = '0;
  logic [CSW-1:0]    CH_SEL = '0;
  logic [DW-1:0]     TRG_LV_UP = '0, TRG_LV_DOWN = '0;
  logic [1:0]        MODE = '0;
  logic [DLY_W-1:0]  DELAY = '0;
  logic [HO_W-1:0]   HOLDOFF = '0, POST_CNT = '0;
  logic              TRG_EV_EN = 1'b0, TRG_BYPASS = 1'b0;
  logic              trig_out, capture_done, armed;
  logic [CSW-1:0]    trig_ch;

  adc_trig_mc #(.DW(DW), .NCH(NCH), .DLY_W(DLY_W), .HO_W(HO_W)) dut (
    .CLK(CLK), .RST(RST), .CLK_EN(CLK_EN), .DATA_IN(DATA_IN), .CH_SEL(CH_SEL),
    .TRG_LV_UP(TRG_LV_UP), .TRG_LV_DOWN(TRG_LV_DOWN), .MODE(MODE), .DELAY(DELAY),
    .HOLDOFF(HOLDOFF), .POST_CNT(POST_CNT), .TRG_EV_EN(TRG_EV_EN), .TRG_BYPASS(TRG_BYPASS),
    .trig_out(trig_out), .capture_done(capture_done), .armed(armed), .trig_ch(trig_ch)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic           trig;
    logic           done;
    logic           armd;
    logic [CSW-1:0] ch;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: counts enabled samples and consecutive-condition runs since arm.
  int m_s1[NCH];
  bit m_first, m_last;
  int m_ch, m_mode, m_dly, m_ho, m_post;
  bit m_armed, m_found, m_trig, m_done;
  int m_skipped, m_run, m_post_seen;

  function automatic void model_reset();
    foreach (m_s1[c]) m_s1[c] = 0;
    m_first = 0; m_last = 0;
    m_ch = 0; m_mode = 0; m_dly = 0; m_ho = 0; m_post = 0;
    m_armed = 0; m_found = 0; m_trig = 0; m_done = 0;
    m_skipped = 0; m_run = 0; m_post_seen = 0;
  endfunction

  function automatic void model_edge();
    int d, up, dn;
    bit is_hi, is_lo, is_in, nf, nl, hunting;
    exp_t e;
    d  = m_s1[m_ch];
    up = int'(TRG_LV_UP);
    dn = int'(TRG_LV_DOWN);
    is_hi = d > up;
    is_lo = d < dn;
    is_in = (d > dn) && (d < up);
    case (m_mode)
      0: begin nf = is_lo;  nl = is_hi;  end
      1: begin nf = is_hi;  nl = is_lo;  end
      2: begin nf = !is_in; nl = is_in;  end
      default: begin nf = is_in; nl = !is_in; end
    endcase
    hunting = m_armed && (m_skipped >= m_ho) && !m_trig;
    if (!TRG_EV_EN) begin
      m_armed = 0; m_trig = 0; m_done = 0;
    end else if (!m_armed) begin
      m_ch = int'(CH_SEL); m_mode = int'(MODE); m_dly = int'(DELAY);
      m_ho = int'(HOLDOFF); m_post = int'(POST_CNT);
      m_armed = 1; m_skipped = 0; m_run = 0; m_found = 0;
      m_trig = 0; m_done = 0; m_post_seen = 0;
    end else if (CLK_EN) begin
      if (m_skipped < m_ho) m_skipped++;
      else if (!m_found) begin
        m_run = m_first ? m_run + 1 : 0;
        if (m_run > m_dly) m_found = 1;
      end else if (!m_trig) begin
        if (m_last) begin
          m_trig = 1; m_post_seen = 0; m_done = (m_post == 0);
        end
      end else if (!m_done) begin
        m_post_seen++;
        if (m_post_seen == m_post) m_done = 1;
      end
    end
    m_first = nf;
    m_last  = nl;
    for (int c = 0; c < NCH; c++) m_s1[c] = int'(DATA_IN[c*DW +: DW]);
    e.trig = TRG_BYPASS | m_trig;
    e.done = m_done;
    e.armd = hunting;
    e.ch   = CSW'(m_ch);
    exp_q.push_back(e);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("trig_out", 16'(trig_out), 16'(e.trig));
        check("capture_done", 16'(capture_done), 16'(e.done));
        check("armed", 16'(armed), 16'(e.armd));
        check("trig_ch", 16'(trig_ch), 16'(e.ch));
      end
    end
  end

  task automatic cyc(input bit en, input bit ev, input logic [7:0] d0, input logic [7:0] d1);
    CLK_EN = en; TRG_EV_EN = ev; DATA_IN = {d1, d0};
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic cfg(input int ch, input int md, input int up, input int dn,
                     input int dly, input int ho, input int post);
    CH_SEL = CSW'(ch); MODE = 2'(md); TRG_LV_UP = 8'(up); TRG_LV_DOWN = 8'(dn);
    DELAY = DLY_W'(dly); HOLDOFF = HO_W'(ho); POST_CNT = HO_W'(post);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 8'h80, 8'h80);
  endtask

  initial begin : driver
    logic [7:0] v0, v1;
    model_reset();
    #2;
    check("rst_trig", 16'(trig_out), 16'h0);
    check("rst_done", 16'(capture_done), 16'h0);
    check("rst_armed", 16'(armed), 16'h0);
    check("rst_ch", 16'(trig_ch), 16'h0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;

    // Rise, deglitched: three low samples then high triggers; two lows do not.
    cfg(0, 0, 8'hC0, 8'h40, 2, 0, 0);
    idle(3);
    cyc(1, 1, 8'h80, 8'h80);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h30, 8'h80);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'hD0, 8'h80);
    check("rise_trig", 16'(trig_out), 16'h1);
    idle(3);
    cyc(1, 1, 8'h80, 8'h80);
    for (int i = 0; i < 2; i++) cyc(1, 1, 8'h30, 8'h80);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'hD0, 8'h80);
    check("rise_short_notrig", 16'(trig_out), 16'h0);

    // Fall with a glitch that reloads the deglitch count.
    idle(3);
    cfg(0, 1, 8'hC0, 8'h40, 3, 0, 0);
    cyc(1, 1, 8'h80, 8'h80);
    cyc(1, 1, 8'hD0, 8'h80); cyc(1, 1, 8'hD0, 8'h80); cyc(1, 1, 8'h80, 8'h80);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'hD0, 8'h80);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'h10, 8'h80);
    check("glitch_trig", 16'(trig_out), 16'h1);

    // Window-exit on channel 1 with holdoff and post count; channel 0 is noise.
    idle(3);
    cfg(1, 3, 8'hC0, 8'h40, 0, 5, 4);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'($urandom), 8'h80);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'($urandom), 8'hF0);
    check("winexit_ch", 16'(trig_ch), 16'h1);
    check("winexit_done", 16'(capture_done), 16'h1);

    // Same kind of run with CLK_EN alternating.
    idle(3);
    cfg(0, 0, 8'hC0, 8'h40, 1, 3, 2);
    for (int i = 0; i < 12; i++) cyc(i % 2 == 0, 1, 8'h30, 8'h80);
    for (int i = 0; i < 14; i++) cyc(i % 2 == 0, 1, 8'hD0, 8'h80);
    check("gated_done", 16'(capture_done), 16'h1);

    // Disarm on the same edge as a trigger, then re-arm in fall mode.
    idle(3);
    cfg(0, 0, 8'hC0, 8'h40, 0, 0, 0);
    cyc(1, 1, 8'h80, 8'h80);
    cyc(1, 1, 8'h30, 8'h80);
    cyc(1, 1, 8'hD0, 8'h80);
    cyc(1, 1, 8'hD0, 8'h80);
    cyc(1, 0, 8'hD0, 8'h80);
    check("collide_trig", 16'(trig_out), 16'h0);
    cfg(0, 1, 8'hC0, 8'h40, 0, 0, 0);
    cyc(1, 1, 8'h80, 8'h80);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'hD0, 8'h80);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h10, 8'h80);
    check("rearm_trig", 16'(trig_out), 16'h1);

    // Async reset mid-POST, then bypass while disarmed.
    idle(3);
    cfg(1, 0, 8'hC0, 8'h40, 0, 0, 20);
    cyc(1, 1, 8'h80, 8'h80);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h80, 8'h30);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'h80, 8'hD0);
    check("pre_reset_trig", 16'(trig_out), 16'h1);
    #2 RST = 1'b0;
    #1;
    check("midrst_trig", 16'(trig_out), 16'h0);
    check("midrst_ch", 16'(trig_ch), 16'h0);
    check("midrst_armed", 16'(armed), 16'h0);
    RST = 1'b1;
    model_reset();
    TRG_BYPASS = 1'b1;
    idle(3);
    check("bypass_trig", 16'(trig_out), 16'h1);
    TRG_BYPASS = 1'b0;

    // Randomized episodes.
    for (int ep = 0; ep < 30; ep++) begin
      cfg($urandom_range(0, 1), $urandom_range(0, 3),
          ($urandom % 6 == 0) ? $urandom_range(0, 255) : $urandom_range(8'h90, 8'hE0),
          ($urandom % 6 == 0) ? $urandom_range(0, 255) : $urandom_range(8'h20, 8'h70),
          $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4));
      TRG_BYPASS = ($urandom % 8 == 0);
      v0 = 8'($urandom); v1 = 8'($urandom);
      for (int i = 0; i < 50; i++) begin
        if ($urandom % 3 == 0) v0 = 8'($urandom);
        if ($urandom % 3 == 0) v1 = 8'($urandom);
        cyc($urandom % 4 != 0, (i >= 2) && ($urandom % 40 != 0), v0, v1);
      end
    end

    @(negedge CLK);
    check("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
